pong_tick_gen: RTL and testbench
================================

// Module: pong_tick_gen
// PURPOSE
//  Parametrised multi-channel game-tick generator for the two-player Pong datapath.
//  Produces NUM_CH independent single-cycle tick pulses from one clk (ball motion,
//  paddle motion, score blink, ...), each with a runtime period, pause/restart control,
//  and a score-driven speed-up: channels in SPEEDUP_MASK shorten their period as the
//  combined player score rises. Also drives a 50%-style phase toggle per channel.
//  Replaces the single fixed-period, start-gated divider.
// PARAMETERS
//  NUM_CH        3        number of tick channels
//  CNT_W         32       period/counter width (bits)
//  SCORE_W       8        width of each player score input
//  LEVEL_SHIFT   2        speed level = (p1+p2) >> LEVEL_SHIFT
//  MAX_LEVEL     15       speed level saturates here
//  STEP          2000000  period reduction (clk cycles) per speed level
//  MIN_PERIOD    4000000  floor for sped-up periods (never applied to period 0)
//  SPEEDUP_MASK  3'b001   bit i=1 -> channel i uses score speed-up
// PORTS
//  clk            in   1               system clock
//  reset          in   1               asynchronous, active-high reset
//  pause          in   1               1 = freeze all counters, no ticks
//  restart        in   1               sync pulse: all channels to IDLE, level to 0
//  base_period    in   NUM_CH x CNT_W  nominal period per channel; 0 = channel off
//  player1_score  in   SCORE_W         current score, player 1
//  player2_score  in   SCORE_W         current score, player 2
//  tick           out  NUM_CH          1-cycle pulse per elapsed period
//  phase          out  NUM_CH          toggles on every tick of that channel
//  level          out  4               registered current speed level
// BEHAVIOUR
//  Reset (async, high): tick=0, phase=0, level=0, every channel in IDLE with cnt=0.
//  Level: sum = p1+p2 computed SCORE_W+1 bits (no overflow); lvl_next =
//   min(sum>>LEVEL_SHIFT, MAX_LEVEL); registered every cycle regardless of pause.
//   restart forces level=0 that cycle. 1-cycle latency score->level.
//  Effective period eff[i] (comb.): base_period[i]==0 -> 0; else if mask bit clear ->
//   base; else red = STEP*level (CNT_W+4 bits, no wrap); eff = (red >= base) ?
//   MIN_PERIOD : max(base-red, MIN_PERIOD); if base < MIN_PERIOD, eff = base.
//  Channel FSM (per channel), states IDLE, COUNT; down-counter cnt:
//   IDLE : if !pause && eff!=0 -> cnt<=eff-1, go COUNT. No tick.
//   COUNT: pause -> hold cnt and state, tick=0.
//          cnt!=0 -> cnt--.
//          cnt==0 -> tick=1 (registered, exactly one cycle), phase toggles;
//                    eff!=0 -> cnt<=eff-1, stay COUNT; eff==0 -> IDLE.
//  eff is sampled only at load/reload: period changes (base or level) take effect at
//   the next period boundary, never mid-period.
//  Timing: from first unpaused IDLE cycle, first tick after eff+1 clk; thereafter one
//   tick every eff clk while unpaused. eff=1 -> tick every cycle after first.
//  restart (priority over pause and counting): all channels -> IDLE, cnt=0, tick=0,
//   phase=0 next cycle. Ticks never emitted in the restart cycle.
//  pause & restart same cycle: restart wins; channels then wait in IDLE until unpaused.
//  Pause asserted the cycle cnt==0: tick suppressed, delivered on first unpaused cycle.
//  Reset mid-period: immediate return to reset state; no partial tick.
//  Channels fully independent; simultaneous ticks on several channels are legal.
// STRUCTURE
//  pong_pkg: typedef logic [CNT_W-1:0] period_t; enum {IDLE, COUNT} tick_state_t;
//   shared default constants (tick period for 100 MHz clk, MIN_PERIOD, STEP).
//  Sub-module tick_channel (one FSM + counter + phase), instantiated NUM_CH times in a
//   generate loop; level and eff computation live in pong_tick_gen.
// TESTING
//  1 reset, base={0,3,5}, no pause, scores 0 -> ch0 never ticks; ch1 first tick cycle 4,
//    then every 3; ch2 first at cycle 6, then every 5; phase toggles on each tick.
//  2 base[0]=10, STEP=2, MIN_PERIOD=4, LEVEL_SHIFT=2, scores 3+5 -> level=2 after 1 clk;
//    in-flight period stays 10, following periods are 6; scores 40+40 -> level 15,
//    period clamps to 4.
//  3 base=4 running, pause held 7 cycles across cnt==0 -> no tick while paused; tick on
//    first unpaused cycle, then every 4.
//  4 restart pulse mid-period with pause=1 -> next cycle tick=0, phase=0, level=0;
//    no ticks until pause drops, then first tick after eff+1 clk.
//  5 base=1 -> after first tick, tick high every cycle; base 1->0 mid-run -> channel
//    returns to IDLE at next boundary, no further ticks.
//  6 async reset asserted between clk edges mid-count -> outputs 0 immediately;
//    after release, counting restarts from IDLE timing of scenario 1.

Source files
------------

// File: rtl/pong_tick_gen_pkg.sv
// rtl/pong_tick_gen_pkg.sv - shared types and default constants for the Pong tick generator
// Purpose : period type, channel state encoding and default timing constants
//           for a 100 MHz system clock.
// Ports   : none (package)
package pong_tick_gen_pkg;

    localparam int CNT_W_DEF      = 32;
    localparam int LEVEL_W        = 4;
    localparam int MIN_PERIOD_DEF = 4_000_000;   // 40 ms at 100 MHz
    localparam int STEP_DEF       = 2_000_000;   // 20 ms shaved off per level

    typedef logic [CNT_W_DEF-1:0] period_t;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } tick_state_t;

endpackage

// File: rtl/pong_tick_gen_if.sv
// rtl/pong_tick_gen_if.sv - control/status bundle between game logic and the tick generator
// Purpose : groups pause/restart, per-channel periods, scores and tick outputs.
// Ports   : master drives pause, restart, base_period, player1/2_score and
//           receives tick, phase, level; slave is the generator side.
interface pong_tick_gen_if #(
    parameter int NUM_CH  = 3,
    parameter int CNT_W   = 32,
    parameter int SCORE_W = 8
);
    logic                           pause;
    logic                           restart;
    logic [NUM_CH-1:0][CNT_W-1:0]   base_period;
    logic [SCORE_W-1:0]             player1_score;
    logic [SCORE_W-1:0]             player2_score;
    logic [NUM_CH-1:0]              tick;
    logic [NUM_CH-1:0]              phase;
    logic [3:0]                     level;

    modport master (
        output pause, restart, base_period, player1_score, player2_score,
        input  tick, phase, level
    );

    modport slave (
        input  pause, restart, base_period, player1_score, player2_score,
        output tick, phase, level
    );
endinterface

// File: rtl/pong_tick_gen_channel.sv
// rtl/pong_tick_gen_channel.sv - one tick channel: IDLE/COUNT FSM, down-counter, phase toggle
// Purpose : emits a one-cycle tick every eff_i cycles, sampling eff_i only at
//           load/reload so period changes land on period boundaries.
// Ports   : clk, reset (async high); pause_i, restart_i controls; eff_i effective
//           period (0 = off); tick_o registered pulse; phase_o toggles per tick.
module pong_tick_gen_channel
    import pong_tick_gen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pause_i,
    input  logic             restart_i,
    input  logic [CNT_W-1:0] eff_i,
    output logic             tick_o,
    output logic             phase_o
);

    tick_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             phase_q, phase_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        phase_d = phase_q;
        if (restart_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            phase_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!pause_i && eff_i != '0) begin
                        cnt_d   = eff_i - CNT_W'(1);
                        state_d = COUNT;
                    end
                end
                COUNT: begin
                    // A pause while cnt==0 simply holds here, so the tick is
                    // delivered on the first unpaused cycle.
                    if (!pause_i) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end else begin
                            tick_d  = 1'b1;
                            phase_d = ~phase_q;
                            if (eff_i != '0) begin
                                cnt_d = eff_i - CNT_W'(1);
                            end else begin
                                cnt_d   = '0;
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign tick_o  = tick_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/pong_tick_gen.sv
// rtl/pong_tick_gen.sv - multi-channel game tick generator with score-driven speed-up
// Purpose : registers the speed level from the combined score, derives each
//           channel's effective period and runs NUM_CH independent tick channels.
// Ports   : clk, reset (async high); bus (slave): pause, restart, base_period,
//           player1/2_score in; tick, phase, level out.
module pong_tick_gen
    import pong_tick_gen_pkg::*;
#(
    parameter int                NUM_CH       = 3,
    parameter int                CNT_W        = CNT_W_DEF,
    parameter int                SCORE_W      = 8,
    parameter int                LEVEL_SHIFT  = 2,
    parameter int                MAX_LEVEL    = 15,
    parameter int                STEP         = STEP_DEF,
    parameter int                MIN_PERIOD   = MIN_PERIOD_DEF,
    parameter logic [NUM_CH-1:0] SPEEDUP_MASK = NUM_CH'(1)
) (
    input  logic               clk,
    input  logic               reset,
    pong_tick_gen_if.slave     bus
);

    localparam logic [CNT_W-1:0]   MIN_P     = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W+3:0]   MIN_P_EXT = (CNT_W+4)'(MIN_PERIOD);

    // Speed level: sum kept one bit wider so two full scores cannot wrap.
    logic [SCORE_W:0]      score_sum;
    logic [SCORE_W:0]      lvl_raw;
    logic [LEVEL_W-1:0]    level_q, level_d;

    assign score_sum = {1'b0, bus.player1_score} + {1'b0, bus.player2_score};
    assign lvl_raw   = score_sum >> LEVEL_SHIFT;

    always_comb begin
        level_d = (lvl_raw > (SCORE_W+1)'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL)
                                                     : lvl_raw[LEVEL_W-1:0];
        if (bus.restart) begin
            level_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign bus.level = level_q;

    // Reduction is 4 bits wider than the counter so STEP*level never wraps.
    logic [CNT_W+3:0]   red;
    logic [NUM_CH-1:0]  tick_w;
    logic [NUM_CH-1:0]  phase_w;

    assign red = (CNT_W+4)'(STEP) * (CNT_W+4)'(level_q);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] base;
        logic [CNT_W-1:0] eff;
        logic [CNT_W+3:0] base_ext;
        logic [CNT_W+3:0] diff;

        assign base     = bus.base_period[i];
        assign base_ext = {4'b0, base};
        assign diff     = base_ext - red;

        // Periods already below the floor are left alone; period 0 stays off.
        always_comb begin
            eff = base;
            if (base == '0) begin
                eff = '0;
            end else if (SPEEDUP_MASK[i] && base >= MIN_P) begin
                if (red >= base_ext || diff < MIN_P_EXT) begin
                    eff = MIN_P;
                end else begin
                    eff = diff[CNT_W-1:0];
                end
            end
        end

        pong_tick_gen_channel #(
            .CNT_W (CNT_W)
        ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .pause_i   (bus.pause),
            .restart_i (bus.restart),
            .eff_i     (eff),
            .tick_o    (tick_w[i]),
            .phase_o   (phase_w[i])
        );
    end

    assign bus.tick  = tick_w;
    assign bus.phase = phase_w;

endmodule

// File: tb/tb_pong_tick_gen.sv
// tb/tb_pong_tick_gen.sv - self-checking bench for pong_tick_gen
module tb_pong_tick_gen;
    import pong_tick_gen_pkg::*;

    localparam int              NUM_CH  = 3;
    localparam int              CNT_W   = 32;
    localparam int              SCORE_W = 8;
    localparam int              LS      = 2;
    localparam int              MAXL    = 15;
    localparam int              STEP    = 2;
    localparam int              MINP    = 4;
    localparam logic [2:0]      MASK    = 3'b001;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pong_tick_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SCORE_W(SCORE_W)) bus ();

    pong_tick_gen #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SCORE_W(SCORE_W), .LEVEL_SHIFT(LS),
        .MAX_LEVEL(MAXL), .STEP(STEP), .MIN_PERIOD(MINP), .SPEEDUP_MASK(MASK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: per channel, unpaused cycles elapsed since the last
    // load/tick, and the period length latched at that moment.
    bit m_run [NUM_CH];
    int m_el  [NUM_CH];
    int m_tgt [NUM_CH];
    bit m_ph  [NUM_CH];
    bit m_tk  [NUM_CH];
    int m_lvl;

    function automatic int eff_m(int base, int lvl, bit masked);
        int red;
        if (base == 0) return 0;
        if (!masked || base < MINP) return base;
        red = STEP * lvl;
        if (red >= base) return MINP;
        return (base - red < MINP) ? MINP : base - red;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_run[c] = 0; m_el[c] = 0; m_tgt[c] = 0; m_ph[c] = 0; m_tk[c] = 0;
        end
        m_lvl = 0;
    endtask

    task automatic model_step();
        int e, sum;
        for (int c = 0; c < NUM_CH; c++) begin
            e = eff_m(int'(bus.base_period[c]), m_lvl, MASK[c]);
            m_tk[c] = 0;
            if (bus.restart) begin
                m_run[c] = 0; m_el[c] = 0; m_ph[c] = 0;
            end else if (!bus.pause) begin
                if (!m_run[c]) begin
                    if (e != 0) begin
                        m_run[c] = 1; m_el[c] = 0; m_tgt[c] = e;
                    end
                end else begin
                    m_el[c]++;
                    if (m_el[c] >= m_tgt[c]) begin
                        m_tk[c] = 1;
                        m_ph[c] = ~m_ph[c];
                        m_el[c] = 0;
                        if (e != 0) m_tgt[c] = e;
                        else        m_run[c] = 0;
                    end
                end
            end
        end
        sum = int'(bus.player1_score) + int'(bus.player2_score);
        m_lvl = bus.restart ? 0 : ((sum >> LS) > MAXL ? MAXL : (sum >> LS));
    endtask

    task automatic chk(string tag, int got, int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        logic [NUM_CH-1:0] et, ep;
        for (int c = 0; c < NUM_CH; c++) begin
            et[c] = m_tk[c];
            ep[c] = m_ph[c];
        end
        checks++;
        assert (bus.tick === et) else begin
            failures++;
            $error("FAIL tick cyc=%0d got=%b exp=%b", cyc, bus.tick, et);
        end
        checks++;
        assert (bus.phase === ep) else begin
            failures++;
            $error("FAIL phase cyc=%0d got=%b exp=%b", cyc, bus.phase, ep);
        end
        checks++;
        assert (bus.level === 4'(m_lvl)) else begin
            failures++;
            $error("FAIL level cyc=%0d got=%0d exp=%0d", cyc, bus.level, m_lvl);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check_all();
    endtask

    task automatic set_base(int b0, int b1, int b2);
        bus.base_period[0] = period_t'(b0);
        bus.base_period[1] = period_t'(b1);
        bus.base_period[2] = period_t'(b2);
    endtask

    task automatic do_restart();
        bus.restart = 1'b1;
        cycle();
        bus.restart = 1'b0;
    endtask

    int first1, first2, s, ntk;
    int tq[$];
    int base_set[8] = '{0, 1, 2, 3, 5, 8, 10, 13};

    initial begin
        reset = 1'b1;
        bus.pause = 1'b0;
        bus.restart = 1'b0;
        bus.player1_score = '0;
        bus.player2_score = '0;
        set_base(0, 3, 5);
        model_reset();
        #13;
        chk("reset_tick", int'(bus.tick), 0);
        chk("reset_phase", int'(bus.phase), 0);
        chk("reset_level", int'(bus.level), 0);
        #3 reset = 1'b0;

        // Scenario 1: base {0,3,5}, scores 0
        first1 = 0; first2 = 0; ntk = 0;
        for (int k = 1; k <= 14; k++) begin
            cycle();
            if (first1 == 0 && bus.tick[1]) first1 = k;
            if (first2 == 0 && bus.tick[2]) first2 = k;
            if (bus.tick[0]) ntk++;
        end
        chk("s1_first_ch1", first1, 4);
        chk("s1_first_ch2", first2, 6);
        chk("s1_ch0_off", ntk, 0);

        // Scenario 2: speed-up on ch0, change lands at next boundary
        set_base(10, 0, 0);
        do_restart();
        s = cyc;
        cycle(); cycle();
        bus.player1_score = 8'd3; bus.player2_score = 8'd5;
        cycle();
        chk("s2_level2", int'(bus.level), 2);
        tq.delete();
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (bus.tick[0]) tq.push_back(cyc);
        end
        chk("s2_first_gap", tq[0] - s, 11);
        chk("s2_next_gap", tq[1] - tq[0], 6);
        bus.player1_score = 8'd40; bus.player2_score = 8'd40;
        tq.delete();
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (bus.tick[0]) tq.push_back(cyc);
        end
        chk("s2_level15", int'(bus.level), 15);
        chk("s2_clamp_gap", tq[tq.size()-1] - tq[tq.size()-2], 4);

        // Scenario 3: pause held across cnt==0
        bus.player1_score = '0; bus.player2_score = '0;
        set_base(0, 4, 0);
        do_restart();
        for (int k = 0; k < 8; k++) cycle();
        bus.pause = 1'b1;
        ntk = 0;
        for (int k = 0; k < 7; k++) begin
            cycle();
            if (bus.tick != '0) ntk++;
        end
        chk("s3_no_tick_paused", ntk, 0);
        bus.pause = 1'b0;
        cycle();
        chk("s3_tick_on_unpause", int'(bus.tick[1]), 1);
        for (int k = 0; k < 9; k++) cycle();

        // Scenario 4: restart with pause mid-period
        bus.player1_score = 8'd20; bus.player2_score = 8'd20;
        set_base(10, 4, 5);
        for (int k = 0; k < 7; k++) cycle();
        bus.pause = 1'b1; bus.restart = 1'b1;
        cycle();
        bus.restart = 1'b0;
        chk("s4_tick0", int'(bus.tick), 0);
        chk("s4_phase0", int'(bus.phase), 0);
        chk("s4_level0", int'(bus.level), 0);
        for (int k = 0; k < 5; k++) cycle();
        bus.pause = 1'b0;
        first1 = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (first1 == 0 && bus.tick[1]) first1 = k;
        end
        chk("s4_first_ch1", first1, 5);

        // Scenario 5: period 1, then switched off
        bus.player1_score = '0; bus.player2_score = '0;
        set_base(0, 0, 1);
        do_restart();
        cycle();
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("s5_every_cycle", int'(bus.tick[2]), 1);
        end
        set_base(0, 0, 0);
        cycle();
        ntk = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (bus.tick[2]) ntk++;
        end
        chk("s5_off", ntk, 0);

        // Scenario 6: async reset between edges
        set_base(0, 3, 5);
        do_restart();
        for (int k = 0; k < 7; k++) cycle();
        #2 reset = 1'b1;
        #1;
        chk("s6_tick0", int'(bus.tick), 0);
        chk("s6_phase0", int'(bus.phase), 0);
        chk("s6_level0", int'(bus.level), 0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        first1 = 0; first2 = 0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (first1 == 0 && bus.tick[1]) first1 = k;
            if (first2 == 0 && bus.tick[2]) first2 = k;
        end
        chk("s6_first_ch1", first1, 4);
        chk("s6_first_ch2", first2, 6);

        // Randomised run against the model
        for (int k = 0; k < 600; k++) begin
            bus.pause   = ($urandom_range(0, 7) == 0);
            bus.restart = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 14) == 0) begin
                bus.player1_score = 8'($urandom_range(0, 255));
                bus.player2_score = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 19) == 0) begin
                bus.base_period[$urandom_range(0, 2)] =
                    period_t'(base_set[$urandom_range(0, 7)]);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
